// File: rtl/spi_peripheral_if.sv
// spi_peripheral_if: bundle of all non-clock/reset signals of spi_peripheral.
//
// Signals:
//   cpol, cpha               SPI mode, latched at frame start
//   mosi_width, miso_width   bits received / transmitted per frame, latched at frame start
//   tx_data                  response word, field tx_data[miso_width-1:0]
//   rx_data, rx_valid        received field (right-aligned) and its one-cycle strobe
//   tx_done, frame_error     one-cycle strobes on CS rise after a complete / incomplete frame
//   busy                     high from frame start until return to idle
//   cs, sclk, mosi           SPI pins, asynchronous to clk
//   miso, miso_oe            registered serial output and its tri-state enable
//   fsm_state                debug view of the peripheral state machine
//
// Modports: slave = the peripheral, master = whatever drives the SPI link.
interface spi_peripheral_if;
  logic        cpol;
  logic        cpha;
  logic [7:0]  mosi_width;
  logic [7:0]  miso_width;
  logic [31:0] tx_data;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        tx_done;
  logic        frame_error;
  logic        busy;
  logic        cs;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [1:0]  fsm_state;

  modport slave (
    input  cpol, cpha, mosi_width, miso_width, tx_data, cs, sclk, mosi,
    output rx_data, rx_valid, tx_done, frame_error, busy, miso, miso_oe, fsm_state
  );

  modport master (
    output cpol, cpha, mosi_width, miso_width, tx_data, cs, sclk, mosi,
    input  rx_data, rx_valid, tx_done, frame_error, busy, miso, miso_oe, fsm_state
  );
endinterface

// File: rtl/spi_peripheral.sv
// spi_peripheral: oversampled SPI responder. CS/SCLK/MOSI are synchronized to
// clk; a frame first receives mosi_width bits, then drives miso_width bits,
// both right-aligned and MSB first. CPOL/CPHA, widths and tx_data are latched
// on the synchronized CS falling edge.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      spi_peripheral_if.slave (config, data, strobes, SPI pins, debug state)
//
// Handshake: rx_valid, tx_done and frame_error are single-cycle strobes with no
// ready/backpressure; rx_data is stable from one rx_valid to the next.
module spi_peripheral #(
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            reset_n,
  spi_peripheral_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RECV, SEND, WAIT_CS} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   cs_prev;
  logic                   sclk_prev;

  logic        cpol_r;
  logic        cpha_r;
  logic [7:0]  mosi_w_r;
  logic [7:0]  miso_w_r;
  logic [31:0] tx_r;
  logic [31:0] rx_shift;
  logic [7:0]  cnt;
  logic [7:0]  idx;

  logic [31:0] rx_data_r;
  logic        rx_valid_r;
  logic        tx_done_r;
  logic        frame_error_r;
  logic        busy_r;
  logic        miso_r;
  logic        miso_oe_r;

  logic        cs_s, sclk_s, mosi_s;
  logic        cs_fall, cs_rise;
  logic        sclk_rise, sclk_fall;
  logic        lead_edge, trail_edge, sample_edge;
  logic [31:0] rx_next;
  logic        last_rx_cycle, last_tx_cycle;

  // Bit of the response word at index i; indices beyond the 32-bit word send 0.
  function automatic logic tx_bit(input logic [31:0] d, input logic [7:0] i);
    return (i < 8'd32) ? d[i[4:0]] : 1'b0;
  endfunction

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign cs_fall   = cs_prev & ~cs_s;
  assign cs_rise   = ~cs_prev & cs_s;
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;

  // Edge detection works on the raw synchronized SCLK and folds CPOL in
  // afterwards, so latching a new CPOL at frame start cannot create a
  // phantom edge.
  assign lead_edge   = cpol_r ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_r ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_r ? trail_edge : lead_edge;

  assign rx_next       = {rx_shift[30:0], mosi_s};
  assign last_rx_cycle = ({1'b0, cnt} + 9'd1) == {1'b0, mosi_w_r};
  assign last_tx_cycle = ({1'b0, cnt} + 9'd1) == {1'b0, miso_w_r};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cs_sync       <= '1;
      sclk_sync     <= '0;
      mosi_sync     <= '0;
      cs_prev       <= 1'b1;
      sclk_prev     <= 1'b0;
      cpol_r        <= 1'b0;
      cpha_r        <= 1'b0;
      mosi_w_r      <= '0;
      miso_w_r      <= '0;
      tx_r          <= '0;
      rx_shift      <= '0;
      cnt           <= '0;
      idx           <= '0;
      rx_data_r     <= '0;
      rx_valid_r    <= 1'b0;
      tx_done_r     <= 1'b0;
      frame_error_r <= 1'b0;
      busy_r        <= 1'b0;
      miso_r        <= 1'b0;
      miso_oe_r     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      cs_prev   <= cs_s;
      sclk_prev <= sclk_s;
      miso_oe_r <= ~cs_s;

      rx_valid_r    <= 1'b0;
      tx_done_r     <= 1'b0;
      frame_error_r <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            cpol_r   <= bus.cpol;
            cpha_r   <= bus.cpha;
            mosi_w_r <= bus.mosi_width;
            miso_w_r <= bus.miso_width;
            tx_r     <= bus.tx_data;
            rx_shift <= '0;
            cnt      <= '0;
            busy_r   <= 1'b1;
            if (bus.mosi_width != 8'd0) begin
              state <= RECV;
            end else if (bus.miso_width != 8'd0) begin
              state <= SEND;
              idx   <= bus.miso_width - 8'd1;
              // CPHA=0 needs the first bit on the wire before the first edge.
              if (!bus.cpha) miso_r <= tx_bit(bus.tx_data, bus.miso_width - 8'd1);
            end else begin
              state <= WAIT_CS;
            end
          end
        end

        RECV: begin
          if (cs_rise) begin
            state         <= IDLE;
            frame_error_r <= 1'b1;
            miso_r        <= 1'b0;
            busy_r        <= 1'b0;
          end else begin
            if (sample_edge) rx_shift <= rx_next;
            if (trail_edge) begin
              if (last_rx_cycle) begin
                // With CPHA=1 the final bit is sampled on this same edge.
                rx_data_r  <= sample_edge ? rx_next : rx_shift;
                rx_valid_r <= 1'b1;
                cnt        <= '0;
                if (miso_w_r != 8'd0) begin
                  state <= SEND;
                  idx   <= miso_w_r - 8'd1;
                  if (!cpha_r) miso_r <= tx_bit(tx_r, miso_w_r - 8'd1);
                end else begin
                  state <= WAIT_CS;
                end
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
        end

        SEND: begin
          if (cs_rise) begin
            state         <= IDLE;
            frame_error_r <= 1'b1;
            miso_r        <= 1'b0;
            busy_r        <= 1'b0;
          end else begin
            if (cpha_r && lead_edge) begin
              miso_r <= tx_bit(tx_r, idx);
              idx    <= idx - 8'd1;
            end
            if (trail_edge) begin
              if (last_tx_cycle) begin
                state <= WAIT_CS;
              end else begin
                cnt <= cnt + 8'd1;
                if (!cpha_r) begin
                  miso_r <= tx_bit(tx_r, idx - 8'd1);
                  idx    <= idx - 8'd1;
                end
              end
            end
          end
        end

        WAIT_CS: begin
          if (cs_rise) begin
            state     <= IDLE;
            miso_r    <= 1'b0;
            tx_done_r <= 1'b1;
            busy_r    <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_data     = rx_data_r;
  assign bus.rx_valid    = rx_valid_r;
  assign bus.tx_done     = tx_done_r;
  assign bus.frame_error = frame_error_r;
  assign bus.busy        = busy_r;
  assign bus.miso        = miso_r;
  assign bus.miso_oe     = miso_oe_r;
  assign bus.fsm_state   = state;

endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed bench for spi_peripheral. The bench acts as the
// SPI master (half period H clk cycles) and checks received data, returned
// MISO bits, strobe counts, abort and reset behaviour against hand-computed
// values.
module tb_spi_peripheral;
  localparam int H = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  spi_peripheral_if bus();

  spi_peripheral #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rv_cnt   = 0;
  int td_cnt   = 0;
  int fe_cnt   = 0;
  logic [63:0] dout;
  logic        miso_pre;
  logic        oe_pre;

  // Count strobe cycles away from the active edge.
  always @(negedge clk) begin
    if (bus.rx_valid)    rv_cnt++;
    if (bus.tx_done)     td_cnt++;
    if (bus.frame_error) fe_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    rv_cnt = 0;
    td_cnt = 0;
    fe_cnt = 0;
  endtask

  // Master driver: one frame of mw MOSI bits then tw MISO bits. Stops after
  // stop_after SCLK cycles; raises CS at the end only if raise_cs is set.
  task automatic run_frame(input logic cpol, input logic cpha, input int mw, input int tw,
                           input logic [63:0] din, input logic [31:0] tx,
                           input int stop_after, input bit raise_cs);
    int n;
    n = mw + tw;
    bus.cpol       = cpol;
    bus.cpha       = cpha;
    bus.mosi_width = mw[7:0];
    bus.miso_width = tw[7:0];
    bus.tx_data    = tx;
    bus.sclk       = cpol;
    bus.mosi       = 1'b0;
    dout           = '0;
    wait_cycles(H);
    bus.cs = 1'b0;
    if (!cpha && mw > 0) bus.mosi = din[mw-1];
    wait_cycles(H);
    miso_pre = bus.miso;
    oe_pre   = bus.miso_oe;
    for (int i = 0; i < n && i < stop_after; i++) begin
      bus.sclk = ~cpol;
      if (!cpha && i >= mw) dout = {dout[62:0], bus.miso};
      if (cpha && i < mw) bus.mosi = din[mw-1-i];
      wait_cycles(H);
      bus.sclk = cpol;
      if (cpha && i >= mw) dout = {dout[62:0], bus.miso};
      if (!cpha && i + 1 < mw) bus.mosi = din[mw-2-i];
      wait_cycles(H);
    end
    if (raise_cs) begin
      bus.cs = 1'b1;
      wait_cycles(H);
    end
  endtask

  task automatic test_reset();
    n_checks++; if (bus.rx_data !== 32'h0) begin n_fail++; $display("FAIL reset_rx_data: got %h expected %h", bus.rx_data, 32'h0); end
    n_checks++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", bus.rx_valid); end
    n_checks++; if (bus.tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_tx_done: got %b expected 0", bus.tx_done); end
    n_checks++; if (bus.frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_frame_error: got %b expected 0", bus.frame_error); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", bus.miso); end
    n_checks++; if (bus.miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_miso_oe: got %b expected 0", bus.miso_oe); end
  endtask

  task automatic test_mode0();
    clear_counts();
    run_frame(1'b0, 1'b0, 8, 8, 64'hA5, 32'h3C, 1000, 1'b1);
    n_checks++; if (bus.rx_data !== 32'h000000A5) begin n_fail++; $display("FAIL mode0_rx_data: got %h expected %h", bus.rx_data, 32'hA5); end
    n_checks++; if (dout !== 64'h3C) begin n_fail++; $display("FAIL mode0_dout: got %h expected %h", dout, 64'h3C); end
    n_checks++; if (rv_cnt !== 1) begin n_fail++; $display("FAIL mode0_rx_valid_count: got %0d expected 1", rv_cnt); end
    n_checks++; if (td_cnt !== 1) begin n_fail++; $display("FAIL mode0_tx_done_count: got %0d expected 1", td_cnt); end
    n_checks++; if (fe_cnt !== 0) begin n_fail++; $display("FAIL mode0_frame_error_count: got %0d expected 0", fe_cnt); end
    n_checks++; if (oe_pre !== 1'b1) begin n_fail++; $display("FAIL mode0_miso_oe: got %b expected 1", oe_pre); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mode0_busy_end: got %b expected 0", bus.busy); end
  endtask

  task automatic test_modes_123();
    for (int m = 1; m < 4; m++) begin
      logic [1:0] mode;
      mode = m[1:0];
      clear_counts();
      run_frame(mode[1], mode[0], 16, 32, 64'hBEEF, 32'hDEADBEEF, 1000, 1'b1);
      n_checks++; if (bus.rx_data !== 32'h0000BEEF) begin n_fail++; $display("FAIL mode%0d_rx_data: got %h expected %h", m, bus.rx_data, 32'hBEEF); end
      n_checks++; if (dout !== 64'hDEADBEEF) begin n_fail++; $display("FAIL mode%0d_dout: got %h expected %h", m, dout, 64'hDEADBEEF); end
      n_checks++; if (rv_cnt !== 1) begin n_fail++; $display("FAIL mode%0d_rx_valid_count: got %0d expected 1", m, rv_cnt); end
      n_checks++; if (td_cnt !== 1) begin n_fail++; $display("FAIL mode%0d_tx_done_count: got %0d expected 1", m, td_cnt); end
    end
  endtask

  task automatic test_tx_only();
    clear_counts();
    run_frame(1'b0, 1'b0, 0, 4, 64'h0, 32'h9, 1000, 1'b1);
    n_checks++; if (miso_pre !== 1'b1) begin n_fail++; $display("FAIL txonly_first_bit: got %b expected 1", miso_pre); end
    n_checks++; if (dout !== 64'h9) begin n_fail++; $display("FAIL txonly_dout: got %h expected %h", dout, 64'h9); end
    n_checks++; if (rv_cnt !== 0) begin n_fail++; $display("FAIL txonly_rx_valid_count: got %0d expected 0", rv_cnt); end
    n_checks++; if (td_cnt !== 1) begin n_fail++; $display("FAIL txonly_tx_done_count: got %0d expected 1", td_cnt); end
    n_checks++; if (bus.rx_data !== 32'h0000BEEF) begin n_fail++; $display("FAIL txonly_rx_hold: got %h expected %h", bus.rx_data, 32'hBEEF); end
  endtask

  task automatic test_frame_error();
    int k;
    clear_counts();
    run_frame(1'b0, 1'b0, 8, 8, 64'h5A, 32'h11, 3, 1'b0);
    bus.cs = 1'b1;
    k = 0;
    while (k < 4 && bus.busy !== 1'b0) begin
      wait_cycles(1);
      k++;
    end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_drop: got %b expected 0 within 4 cycles", bus.busy); end
    wait_cycles(H);
    n_checks++; if (fe_cnt !== 1) begin n_fail++; $display("FAIL abort_frame_error_count: got %0d expected 1", fe_cnt); end
    n_checks++; if (rv_cnt !== 0) begin n_fail++; $display("FAIL abort_rx_valid_count: got %0d expected 0", rv_cnt); end
    n_checks++; if (td_cnt !== 0) begin n_fail++; $display("FAIL abort_tx_done_count: got %0d expected 0", td_cnt); end
    n_checks++; if (bus.rx_data !== 32'h0000BEEF) begin n_fail++; $display("FAIL abort_rx_hold: got %h expected %h", bus.rx_data, 32'hBEEF); end
    clear_counts();
    run_frame(1'b0, 1'b0, 8, 8, 64'h96, 32'hE7, 1000, 1'b1);
    n_checks++; if (bus.rx_data !== 32'h00000096) begin n_fail++; $display("FAIL after_abort_rx_data: got %h expected %h", bus.rx_data, 32'h96); end
    n_checks++; if (dout !== 64'hE7) begin n_fail++; $display("FAIL after_abort_dout: got %h expected %h", dout, 64'hE7); end
  endtask

  task automatic test_reset_mid_send();
    clear_counts();
    run_frame(1'b0, 1'b0, 8, 8, 64'h0F, 32'hFF, 11, 1'b0);
    n_checks++; if (bus.miso !== 1'b1) begin n_fail++; $display("FAIL midsend_miso: got %b expected 1", bus.miso); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midsend_busy: got %b expected 1", bus.busy); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.rx_data !== 32'h0) begin n_fail++; $display("FAIL rst_rx_data: got %h expected %h", bus.rx_data, 32'h0); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.miso !== 1'b0) begin n_fail++; $display("FAIL rst_miso: got %b expected 0", bus.miso); end
    n_checks++; if (bus.miso_oe !== 1'b0) begin n_fail++; $display("FAIL rst_miso_oe: got %b expected 0", bus.miso_oe); end
    n_checks++; if ({bus.rx_valid, bus.tx_done, bus.frame_error} !== 3'b000) begin n_fail++; $display("FAIL rst_strobes: got %b expected 000", {bus.rx_valid, bus.tx_done, bus.frame_error}); end
    wait_cycles(2);
    bus.cs   = 1'b1;
    bus.sclk = 1'b0;
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(H);
    clear_counts();
    run_frame(1'b0, 1'b0, 8, 8, 64'hC3, 32'h5A, 1000, 1'b1);
    n_checks++; if (bus.rx_data !== 32'h000000C3) begin n_fail++; $display("FAIL post_reset_rx_data: got %h expected %h", bus.rx_data, 32'hC3); end
    n_checks++; if (dout !== 64'h5A) begin n_fail++; $display("FAIL post_reset_dout: got %h expected %h", dout, 64'h5A); end
    n_checks++; if (rv_cnt !== 1 || td_cnt !== 1) begin n_fail++; $display("FAIL post_reset_strobes: got rv=%0d td=%0d expected rv=1 td=1", rv_cnt, td_cnt); end
  endtask

  task automatic test_wide_rx();
    clear_counts();
    run_frame(1'b0, 1'b0, 40, 8, 64'hFF12345678, 32'h81, 1000, 1'b1);
    n_checks++; if (bus.rx_data !== 32'h12345678) begin n_fail++; $display("FAIL wide_rx_data: got %h expected %h", bus.rx_data, 32'h12345678); end
    n_checks++; if (dout !== 64'h81) begin n_fail++; $display("FAIL wide_dout: got %h expected %h", dout, 64'h81); end
    n_checks++; if (rv_cnt !== 1) begin n_fail++; $display("FAIL wide_rx_valid_count: got %0d expected 1", rv_cnt); end
  endtask

  initial begin
    bus.cpol       = 1'b0;
    bus.cpha       = 1'b0;
    bus.mosi_width = 8'd8;
    bus.miso_width = 8'd8;
    bus.tx_data    = 32'h0;
    bus.cs         = 1'b1;
    bus.sclk       = 1'b0;
    bus.mosi       = 1'b0;
    reset_n        = 1'b0;
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(3);

    test_reset();
    test_mode0();
    test_modes_123();
    test_tx_only();
    test_frame_error();
    test_reset_mid_send();
    test_wide_rx();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

Oversampled SPI peripheral (responder) that answers `spi_controller` transactions. It sits on the far end of the SPI link in test or loopback fabrics. It samples CS/SCLK/MOSI with a synchronizer on its own clock and honours CPOL/CPHA. Each frame has two halves: it first receives a MOSI-width field, then drives a MISO-width field. Both fields are right-aligned and sent MSB first.

## Interface
- SYNC_STAGES, 2: flip-flop stages on CS, SCLK and MOSI (allowed 2..3).
- CLK  in  1  system clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- CPOL  in  1  SCLK idle level; sampled at frame start.
- CPHA  in  1  0: sample on leading edge, 1: sample on trailing edge; sampled at frame start.
- MOSI_WIDTH  in  8  bits received per frame; sampled at frame start.
- MISO_WIDTH  in  8  bits transmitted per frame; sampled at frame start.
- TX_DATA  in  32  response word; field is TX_DATA[MISO_WIDTH-1:0]; captured at frame start.
- RX_DATA  out  32  received field, right-aligned, zero-extended; holds until the next RX_VALID.
- RX_VALID  out  1  one-cycle pulse when MOSI_WIDTH bits have been captured.
- TX_DONE  out  1  one-cycle pulse when CS rises after a complete frame.
- FRAME_ERROR  out  1  one-cycle pulse when CS rises before the frame is complete.
- BUSY  out  1  high from frame start until the return to IDLE.
- CS  in  1  chip select, active low, asynchronous to CLK.
- SCLK  in  1  serial clock, asynchronous to CLK.
- MOSI  in  1  serial data in.
- MISO  out  1  serial data out, registered.
- MISO_OE  out  1  tri-state enable; high while synchronized CS is low.

## Operation
- Normalized clock s = sync(SCLK) XOR cpol_r.
  - Leading edge: s rises. Trailing edge: s falls.
  - Edges are ignored outside RECV/SEND.
- States are IDLE, RECV, SEND, WAIT_CS.
- IDLE → frame start on a synchronized CS falling edge. At frame start:
  - Latch CPOL, CPHA, both widths and TX_DATA.
  - Clear the RX shift register and the bit counter; assert BUSY.
  - Next state is RECV if MOSI_WIDTH>0, else SEND if MISO_WIDTH>0, else WAIT_CS.
- RECV:
  - Sample MOSI on the leading edge (CPHA=0) or trailing edge (CPHA=1): rx = {rx[30:0], mosi}. Only the last 32 bits are kept when the width exceeds 32.
  - On the trailing edge of SCLK cycle MOSI_WIDTH: copy rx to RX_DATA, pulse RX_VALID, reset the counter, go to SEND (or WAIT_CS if MISO_WIDTH=0).
- SEND (bit index counts down from MISO_WIDTH-1; indices ≥32 send 0):
  - CPHA=0: first bit goes on MISO in the cycle SEND is entered. Each following bit changes on a trailing edge.
  - CPHA=1: each bit changes on a leading edge.
  - After the trailing edge of cycle MISO_WIDTH: go to WAIT_CS.
- WAIT_CS → IDLE on synchronized CS rise: MISO←0, pulse TX_DONE, drop BUSY.
- CS rise in RECV or SEND → IDLE immediately:
  - Pulse FRAME_ERROR; no RX_VALID and no TX_DONE.
  - RX_DATA keeps its previous value; MISO←0.
- SCLK edges while CS is high are ignored. CS fall in any non-IDLE state cannot occur, because CS must rise first.
- Reset (asynchronous, any state including mid-frame) → IDLE:
  - Outputs: RX_DATA=0, RX_VALID=0, TX_DONE=0, FRAME_ERROR=0, BUSY=0, MISO=0, MISO_OE=0.
  - All synchronizer flops reset to their idle levels (CS=1, SCLK=0, MOSI=0).

## Timing
- Pin-to-action latency is SYNC_STAGES+1 CLK cycles after a pin transition (±1 cycle of sampling uncertainty). With the default, MISO changes 3 cycles after the SCLK edge.
- Requirements on the master:
  - SCLK high and low times ≥ SYNC_STAGES+2 CLK cycles.
  - CS fall to first SCLK edge ≥ SYNC_STAGES+2 cycles.
  - Last edge to CS rise ≥ SYNC_STAGES+2 cycles.
  - When driven by spi_controller on the same clock: SCLK_HALF_PERIOD ≥ 4 and DATA_DELAY ≥ 4.
- RX_VALID is asserted SYNC_STAGES+1 cycles after the final RECV trailing edge. At that point TX_DATA is already latched, so the response cannot depend on the received data.
- MISO_OE follows synchronized CS with 1 cycle of register delay.

## Test plan
- Mode 0, MOSI_WIDTH=8, MISO_WIDTH=8, controller DIN=0xA5000000, TX_DATA=0x3C, half period 4 → RX_DATA=0x000000A5, one RX_VALID pulse, controller DOUT=0x0000003C, one TX_DONE.
- Modes 1, 2 and 3, MOSI_WIDTH=16, MISO_WIDTH=32, DIN=0xBEEF0000, TX_DATA=0xDEADBEEF → RX_DATA=0x0000BEEF, DOUT=0xDEADBEEF in every mode.
- MOSI_WIDTH=0, MISO_WIDTH=4, TX_DATA=0x9, CPHA=0 → MISO=1 before the first leading edge, DOUT=0x9, no RX_VALID, TX_DONE=1.
- CS raised after 3 of 8 MOSI bits → FRAME_ERROR pulses once, RX_DATA unchanged, BUSY=0 within 4 cycles, next frame received correctly.
- RESET_N low in mid-SEND → all outputs 0 immediately; the next full 8/8 frame completes correctly.
- MOSI_WIDTH=40, DIN pattern with the last 32 bits = 0x12345678 → RX_DATA=0x12345678.
